// File: rtl/evp_pkg.sv
// Shared definitions for the store-polynomial (STP) stage and the
// polynomial evaluation FSM that later reads the same coefficient/degree RAMs.
//   - stp_state_e : STP controller state encoding
//   - MAX_DEGREE / SLOT_STRIDE : polynomial slot geometry in coefficient RAM S
//   - N_ERR : degree marker written for an illegal degree; the evaluator
//             treats this value as an error
//   - STATUS_* : values reported on the status output
//   - log2 : address-width helper (ceiling log2)
package evp_pkg;

    localparam int          MAX_DEGREE  = 10;
    localparam logic [6:0]  SLOT_STRIDE = 7'd11;
    localparam logic [4:0]  N_ERR       = 5'b11111;

    localparam logic [31:0] STATUS_OK   = 32'h0000_0000;
    localparam logic [31:0] STATUS_ERR  = 32'h0000_0002;
    localparam logic [31:0] STATUS_IDLE = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_CHECK_N  = 3'd2,
        ST_RD_COEFF = 3'd3,
        ST_WR_COEFF = 3'd4,
        ST_WR_N     = 3'd5,
        ST_ERROR    = 3'd6,
        ST_END      = 3'd7
    } stp_state_e;

    // Ceiling log2; a depth of 1 still yields a width of 0.
    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/stp_fsm_if.sv
// Bus bundle between the STP stage and its environment (instruction issue,
// data buffer, coefficient RAM S and degree RAM N).
//   slave  : the STP stage side
//   master : the environment side (issue logic, RAMs, or a testbench)
// AW is the data buffer address width.
interface stp_fsm_if #(
    parameter int AW = 10
);
    logic          start_stp;
    logic [2:0]    A;
    logic [4:0]    N;
    logic [AW-1:0] rd_addr_data;
    logic [15:0]   ram_out_data;
    logic          en_rd_data;
    logic [AW-1:0] rd_addr_data_updated;
    logic          en_wr_S;
    logic [6:0]    wr_addr_S;
    logic [15:0]   wr_data_S;
    logic          en_wr_N;
    logic [2:0]    wr_addr_N;
    logic [4:0]    wr_data_N;
    logic          done_stp;
    logic [31:0]   status;

    modport slave (
        input  start_stp, A, N, rd_addr_data, ram_out_data,
        output en_rd_data, rd_addr_data_updated,
               en_wr_S, wr_addr_S, wr_data_S,
               en_wr_N, wr_addr_N, wr_data_N,
               done_stp, status
    );

    modport master (
        output start_stp, A, N, rd_addr_data, ram_out_data,
        input  en_rd_data, rd_addr_data_updated,
               en_wr_S, wr_addr_S, wr_data_S,
               en_wr_N, wr_addr_N, wr_data_N,
               done_stp, status
    );
endinterface

// File: rtl/stp_fsm.sv
// Store-polynomial stage. On start_stp it copies N+1 coefficient tokens from
// the data buffer into coefficient RAM S at A*11+i, then writes the degree N
// into degree RAM N at address A. An illegal degree (N > max_degree) writes
// N_ERR instead, consumes no tokens and reports STATUS_ERR.
// Ports:
//   clk : system clock
//   rst : asynchronous reset, active low
//   bus : stp_fsm_if.slave (instruction fields, data buffer read port,
//         S/N RAM write ports, done_stp pulse, status)
module stp_fsm
    import evp_pkg::*;
#(
    parameter int buffer_size = 1024,
    parameter int max_degree  = MAX_DEGREE
) (
    input  logic       clk,
    input  logic       rst,
    stp_fsm_if.slave   bus
);

    localparam int            AW       = log2(buffer_size);
    localparam logic [6:0]    STRIDE   = 7'(max_degree + 1);
    localparam logic [4:0]    MAX_N    = 5'(max_degree);
    localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

    stp_state_e    state_r, next_state_s;
    logic [2:0]    A_r;
    logic [4:0]    N_r;
    logic [3:0]    idx_r;
    logic [AW-1:0] rd_addr_r;
    logic [31:0]   status_r;
    // Last values driven with an enable, so the write ports hold when idle.
    logic [6:0]    s_addr_hold_r;
    logic [15:0]   s_data_hold_r;
    logic [2:0]    n_addr_hold_r;
    logic [4:0]    n_data_hold_r;

    logic          last_coeff_s;
    logic [6:0]    s_addr_s;
    logic          en_rd_s, en_wr_s_s, en_wr_n_s, done_s;
    logic [6:0]    wr_addr_s_s;
    logic [15:0]   wr_data_s_s;
    logic [2:0]    wr_addr_n_s;
    logic [4:0]    wr_data_n_s;

    // Max address is 7*11+10 = 87, so 7-bit arithmetic cannot overflow.
    assign s_addr_s     = ({4'b0000, A_r} * STRIDE) + {3'b000, idx_r};
    assign last_coeff_s = ({1'b0, idx_r} == N_r);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Instruction latches, token index, read pointer, status and port holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            A_r           <= 3'd0;
            N_r           <= 5'd0;
            idx_r         <= 4'd0;
            rd_addr_r     <= {AW{1'b0}};
            status_r      <= STATUS_IDLE;
            s_addr_hold_r <= 7'd0;
            s_data_hold_r <= 16'd0;
            n_addr_hold_r <= 3'd0;
            n_data_hold_r <= 5'd0;
        end else begin
            case (state_r)
                ST_START: begin
                    A_r       <= bus.A;
                    N_r       <= bus.N;
                    rd_addr_r <= bus.rd_addr_data;
                    idx_r     <= 4'd0;
                end
                ST_WR_COEFF: begin
                    // Wraps naturally modulo buffer_size (power of two).
                    rd_addr_r     <= rd_addr_r + ADDR_ONE;
                    s_addr_hold_r <= s_addr_s;
                    s_data_hold_r <= bus.ram_out_data;
                    if (!last_coeff_s) begin
                        idx_r <= idx_r + 4'd1;
                    end else begin
                        idx_r <= idx_r;
                    end
                end
                ST_WR_N: begin
                    status_r      <= STATUS_OK;
                    n_addr_hold_r <= A_r;
                    n_data_hold_r <= N_r;
                end
                ST_ERROR: begin
                    status_r      <= STATUS_ERR;
                    n_addr_hold_r <= A_r;
                    n_data_hold_r <= N_ERR;
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state and output decode.
    always_comb begin
        next_state_s = state_r;
        en_rd_s      = 1'b0;
        en_wr_s_s    = 1'b0;
        en_wr_n_s    = 1'b0;
        done_s       = 1'b0;
        wr_addr_s_s  = s_addr_hold_r;
        wr_data_s_s  = s_data_hold_r;
        wr_addr_n_s  = n_addr_hold_r;
        wr_data_n_s  = n_data_hold_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start_stp) begin
                    next_state_s = ST_START;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_START: begin
                next_state_s = ST_CHECK_N;
            end
            ST_CHECK_N: begin
                if (N_r > MAX_N) begin
                    next_state_s = ST_ERROR;
                end else begin
                    next_state_s = ST_RD_COEFF;
                end
            end
            ST_RD_COEFF: begin
                en_rd_s      = 1'b1;
                next_state_s = ST_WR_COEFF;
            end
            ST_WR_COEFF: begin
                // Buffer data requested in RD_COEFF is valid this cycle.
                en_wr_s_s   = 1'b1;
                wr_addr_s_s = s_addr_s;
                wr_data_s_s = bus.ram_out_data;
                if (last_coeff_s) begin
                    next_state_s = ST_WR_N;
                end else begin
                    next_state_s = ST_RD_COEFF;
                end
            end
            ST_WR_N: begin
                en_wr_n_s    = 1'b1;
                wr_addr_n_s  = A_r;
                wr_data_n_s  = N_r;
                next_state_s = ST_END;
            end
            ST_ERROR: begin
                en_wr_n_s    = 1'b1;
                wr_addr_n_s  = A_r;
                wr_data_n_s  = N_ERR;
                next_state_s = ST_END;
            end
            ST_END: begin
                done_s       = 1'b1;
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    assign bus.en_rd_data           = en_rd_s;
    assign bus.rd_addr_data_updated = rd_addr_r;
    assign bus.en_wr_S              = en_wr_s_s;
    assign bus.wr_addr_S            = wr_addr_s_s;
    assign bus.wr_data_S            = wr_data_s_s;
    assign bus.en_wr_N              = en_wr_n_s;
    assign bus.wr_addr_N            = wr_addr_n_s;
    assign bus.wr_data_N            = wr_data_n_s;
    assign bus.done_stp             = done_s;
    assign bus.status               = status_r;

endmodule

// File: doc/stp_fsm.md
Name: stp_fsm

Overview:
- Store-polynomial stage, directly upstream of the polynomial evaluation FSM.
- On an STP instruction it copies N+1 coefficient tokens from the data buffer into coefficient RAM S, slot A (S address = A*11 + i). It then writes degree N into N RAM at address A.
- The evaluation FSM later reads the same S and N locations. An invalid degree writes the error marker 5'b11111 into the N slot, and the evaluator treats that marker as an error.

Parameters:
- buffer_size, 1024: data buffer depth in tokens; power of two; address width log2(buffer_size).
- max_degree, 10: largest legal N; slot stride is max_degree+1 = 11.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active low
- start_stp  in  1  one-cycle start pulse; sampled only in IDLE
- A  in  3  coefficient slot index
- N  in  5  polynomial degree from the instruction
- rd_addr_data  in  log2(buffer_size)  data buffer address of the first coefficient token
- ram_out_data  in  16  data buffer read data; valid the cycle after en_rd_data
- en_rd_data  out  1  data buffer read enable
- rd_addr_data_updated  out  log2(buffer_size)  current/next data read address
- en_wr_S  out  1  S RAM write enable
- wr_addr_S  out  7  S RAM write address
- wr_data_S  out  16  S RAM write data
- en_wr_N  out  1  N RAM write enable
- wr_addr_N  out  3  N RAM write address
- wr_data_N  out  5  N RAM write data
- done_stp  out  1  one-cycle completion pulse
- status  out  32  0 = ok, 2 = degree error, all-ones = idle/never run

Behaviour:
- Reset (async, rst=0), any state → IDLE:
  - all enables, done_stp, counters and rd_addr_data_updated = 0
  - status = 32'hFFFFFFFF
  - a partially written slot stays partial; no cleanup.
- Registered state; outputs decoded from state and registers. Registers: A_r, N_r, idx (4 bits), rd_addr_data_updated, status.
- States:
  - IDLE: waits for start_stp=1 → START. start_stp is ignored in every other state.
  - START: latch A_r=A, N_r=N, rd_addr_data_updated=rd_addr_data, idx=0 → CHECK_N.
  - CHECK_N: N_r > max_degree (11..31) → ERROR; otherwise → RD_COEFF.
  - RD_COEFF: en_rd_data=1 at address rd_addr_data_updated → WR_COEFF.
  - WR_COEFF:
    - en_wr_S=1, wr_addr_S=A_r*11+idx, wr_data_S=ram_out_data
    - rd_addr_data_updated += 1, wrapping modulo buffer_size
    - if idx==N_r → WR_N; else idx += 1 → RD_COEFF.
  - WR_N: en_wr_N=1, wr_addr_N=A_r, wr_data_N=N_r, status=0 → END.
  - ERROR:
    - en_wr_N=1, wr_addr_N=A_r, wr_data_N=5'b11111, status=2
    - no data tokens consumed; rd_addr_data_updated = rd_addr_data (unchanged) → END.
  - END: done_stp=1 for exactly one cycle → IDLE.
- Latency: for a legal N, done_stp is high in cycle 2N+6 after the edge that sampled start_stp. Error path: done_stp high in cycle 4.
- Write-address arithmetic is 7 bits; maximum address is 7*11+10 = 87, so no overflow.
- When not asserted, write data/address outputs hold their last value; the RAMs must ignore them without the enable.
- status and rd_addr_data_updated hold after END until the next START.
- Exactly one S or N write per cycle; S and N writes are never simultaneous.

Decomposition:
- Shared package (evp_pkg):
  - state encodings
  - MAX_DEGREE=10, SLOT_STRIDE=11
  - N_ERR=5'b11111
  - STATUS_OK=0, STATUS_ERR=2, STATUS_IDLE=all-ones
  - log2 function
- Evaluation FSM imports the same constants.
- No sub-module; the address generator (A*11+idx) is inline.

Test Plan:
- Basic store: A=3, N=2, rd_addr_data=100, buffer[100..102]=5,7,9, pulse start → S[33]=5, S[34]=7, S[35]=9, N[3]=2, status=0, rd_addr_data_updated=103, done_stp in cycle 10, one-cycle wide.
- Degree error: A=1, N=11 → single N write N[1]=5'b11111, no S writes, no en_rd_data, status=2, done_stp in cycle 4; repeat with N=31 → same.
- Address wrap and edge slot: A=7, N=1, rd_addr_data=1023, buffer[1023]=0xAAAA, buffer[0]=0x5555 → S[77]=0xAAAA, S[78]=0x5555, rd_addr_data_updated=1; N=0 in a separate run → exactly one S write.
- Max degree: A=7, N=10 → S[77..87] written in order, N[7]=10, done_stp in cycle 26.
- Reset mid-op: assert rst low during WR_COEFF of a N=5 store → immediate IDLE, all enables 0, status=all-ones; next start completes normally.
- Busy start ignored, then back-to-back: start pulses during an operation cause no restart. A start on the cycle after done_stp (IDLE) is accepted, and the evaluation FSM then reads the stored polynomial correctly.
